// File: rtl/inst_mgmt.sv
// Instruction-management stage: picks the word handed to decode each cycle
// (fresh fetch, replay of the last issued word, or a NOP bubble).
module inst_mgmt (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rdata,
    input  logic [1:0]  inst_sel,
    output logic [31:0] inst
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0]  INST_MEM = SEL_W'(2'b00);
    localparam logic [SEL_W-1:0]  INST_OLD = SEL_W'(2'b01);
    localparam logic [SEL_W-1:0]  INST_NOP = SEL_W'(2'b10);
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    logic [INST_W-1:0] inst_old;

    // Source mux; reset and the reserved code both fall through to a NOP.
    always_comb begin
        inst = NOP_INST;
        if (!rst) begin
            case (inst_sel)
                INST_MEM: inst = rdata;
                INST_OLD: inst = inst_old;
                INST_NOP: inst = NOP_INST;
                default:  inst = NOP_INST;
            endcase
        end
    end

    // Replay history tracks whatever was actually issued, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_old <= NOP_INST;
        end else begin
            inst_old <= inst;
        end
    end

endmodule

// File: tb/tb_inst_mgmt.sv
// Scoreboard bench for inst_mgmt: expected words are queued as stimulus is
// applied and compared against inst at the following falling edge.
module tb_inst_mgmt;

    localparam logic [1:0]  SEL_MEM  = 2'b00;
    localparam logic [1:0]  SEL_OLD  = 2'b01;
    localparam logic [1:0]  SEL_NOP  = 2'b10;
    localparam logic [1:0]  SEL_RSV  = 2'b11;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] rdata;
    logic [1:0]  inst_sel;
    logic [31:0] inst;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks;
    int          n_errors;

    inst_mgmt dut (
        .clk      (clk),
        .rst      (rst),
        .rdata    (rdata),
        .inst_sel (inst_sel),
        .inst     (inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic drive(input string tag, input logic r, input logic [1:0] sel,
                         input logic [31:0] data, input logic [31:0] exp);
        @(posedge clk);
        #1;
        rst      = r;
        inst_sel = sel;
        rdata    = data;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, inst, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] fetch_words[5];
        logic [31:0] tail_words[3];
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        inst_sel = SEL_MEM;
        rdata    = 32'h0;
        fetch_words = '{32'd10, 32'd3, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF0};
        tail_words  = '{32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF0};

        drive("reset0", 1'b1, SEL_MEM, 32'hDEAD_BEEF, NOP_WORD);
        drive("reset1", 1'b1, SEL_OLD, 32'h1111_2222, NOP_WORD);

        foreach (fetch_words[i])
            drive($sformatf("fetch%0d", i), 1'b0, SEL_MEM, fetch_words[i], fetch_words[i]);

        drive("replay0", 1'b0, SEL_OLD, 32'h55, 32'hFFFF_FFF0);
        drive("replay1", 1'b0, SEL_OLD, 32'h55, 32'hFFFF_FFF0);

        drive("bubble0", 1'b0, SEL_NOP, 32'h55, NOP_WORD);
        drive("bubble1", 1'b0, SEL_NOP, 32'h66, NOP_WORD);
        drive("bubble_replay", 1'b0, SEL_OLD, 32'h77, NOP_WORD);

        drive("reserved", 1'b0, SEL_RSV, 32'h1234, NOP_WORD);

        drive("pre_reset", 1'b0, SEL_MEM, 32'd3, 32'd3);
        for (int i = 0; i < 3; i++)
            drive($sformatf("mid_reset%0d", i), 1'b1, SEL_MEM, 32'd3, NOP_WORD);
        drive("post_reset_old", 1'b0, SEL_OLD, 32'd3, NOP_WORD);
        foreach (tail_words[i])
            drive($sformatf("post_fetch%0d", i), 1'b0, SEL_MEM, tail_words[i], tail_words[i]);

        drive("iso_load", 1'b0, SEL_MEM, 32'hABCD_0000, 32'hABCD_0000);
        for (int i = 0; i < 5; i++)
            drive($sformatf("iso%0d", i), 1'b0, SEL_OLD, $urandom, 32'hABCD_0000);
        drive("iso_nop", 1'b0, SEL_NOP, $urandom, NOP_WORD);

        @(negedge clk);
        @(posedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
